psum_deskew_acc: RTL and testbench
==================================

Name: psum_deskew_acc

Overview:
- Sits directly below the bottom row of the weight-stationary systolic array and consumes each column's out_psum stream.
- Removes the diagonal skew: column j results arrive j cycles after column 0. After deskew, all columns form one row vector.
- Accumulates row vectors across K-tiles in a local buffer. On the final K-tile it pushes finished rows into an output FIFO with a valid/ready interface.

Parameters:
- N_COLS, 4: number of array columns (vector width in elements).
- DATA_W_OUT, 32: partial-sum and accumulator element width.
- ROWS_MAX, 16: maximum output rows per tile (accumulation buffer depth).
- KT_W, 8: width of the K-tile count field.
- FIFO_DEPTH, 8: output FIFO depth in vectors (power of 2).

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  one-cycle pulse; latches cfg_rows/cfg_ktiles; accepted only in IDLE.
- cfg_rows  in  $clog2(ROWS_MAX+1)  output rows M per K-tile; 0 is treated as 1.
- cfg_ktiles  in  KT_W  number of K-tiles; 0 is treated as 1.
- in_valid  in  1  column-0 psum valid. Column j is implicitly valid j cycles later.
- psum_in  in  N_COLS*DATA_W_OUT  bottom-row psums; column j at [j*DATA_W_OUT +: DATA_W_OUT].
- out_valid  out  1  FIFO not empty.
- out_ready  in  1  consumer accepts out_data.
- out_data  out  N_COLS*DATA_W_OUT  finished row vector, same packing as psum_in.
- busy  out  1  high from accepted start until done.
- done  out  1  one-cycle pulse on the final FIFO push of the job.
- almost_full  out  1  FIFO count >= FIFO_DEPTH-2.
- ovf_err  out  1  sticky: a push was attempted while the FIFO was full with no pop; cleared by start.

Behaviour:
- Reset values: all outputs 0; FSM IDLE; FIFO empty; counters 0; deskew registers and valid shift register cleared. Buffer contents need not be reset (K-tile 0 overwrites them).
- Deskew:
  - Column j passes through N_COLS-1-j registers. Column N_COLS-1 is unregistered.
  - in_valid passes through an N_COLS-1 stage shift register to form aligned_valid.
  - Vector from in_valid at cycle t is aligned in cycle t+N_COLS-1.
- Row/K counters (advance only on aligned_valid while in RUN):
  - row_cnt counts 0..M-1. On wrap, k_cnt increments.
- Accumulate stage (registered, captured at the end of the aligned cycle):
  - k_cnt==0: buf[row_cnt] <= v.
  - 0<k_cnt<K-1: buf[row_cnt] <= buf[row_cnt]+v.
  - k_cnt==K-1: result = (K==1 ? v : buf[row_cnt]+v) is registered, then pushed to the FIFO next cycle.
- Arithmetic: per-element unsigned add, wraps modulo 2^DATA_W_OUT with no saturation.
- Latency: in_valid at cycle t on the last K-tile, with FIFO empty, gives out_valid high in cycle t+N_COLS+1.
- FSM:
  - IDLE -> RUN on start. In RUN, busy=1.
  - RUN -> IDLE on the cycle after the final push (row M-1, k K-1). done pulses in the push cycle.
  - start while in RUN is ignored.
  - aligned_valid in IDLE is ignored: no counting, no push.
- FIFO:
  - Registered output, no fall-through. Pop when out_valid && out_ready.
  - Push and pop in the same cycle when full: both succeed, count unchanged.
  - Push when full with no pop: data dropped, ovf_err set, counters still advance.
  - The array cannot stall, so the controller must use almost_full to throttle issue.
- Reset mid-job: immediate return to IDLE. FIFO flushed, in-flight deskew data discarded, busy/done/ovf_err = 0.

Test Plan:
- N_COLS=4, M=2, K=1; rows {1,2,3,4} then {5,6,7,8}, fed skewed, out_ready=1 -> out_valid 5 cycles after each in_valid; out_data {1,2,3,4} then {5,6,7,8}; done pulses once; busy falls the next cycle.
- M=1, K=3; inputs {1,1,1,1}, {2,2,2,2}, {3,3,3,3} -> exactly one output {6,6,6,6}; no output after tiles 0 and 1.
- M=1, K=2; inputs 0xFFFFFFFF then 2 in every column -> output 1 in every column (wrap-around).
- out_ready=0, M=10, K=1 -> almost_full at count 6; 8 vectors held; rows 9-10 dropped; ovf_err=1; with out_ready then 1, vectors 1-8 drain in order; next start clears ovf_err.
- Pulse start during RUN with different cfg -> ignored; original M/K completes. in_valid while IDLE -> no output, no done.
- Assert rst_n low mid-job with 3 vectors in FIFO -> next cycle out_valid=0, busy=0. A new job after reset produces correct results unaffected by prior buffer contents.

Source files
------------

// File: rtl/psum_deskew_acc.sv
// Deskew and K-tile accumulation stage under the bottom row of a
// weight-stationary systolic array. Column j arrives j cycles after
// column 0. Each column is delayed so that all columns line up, rows
// are summed across K-tiles in a local buffer, and finished rows are
// pushed into a valid/ready output FIFO.

// Per-column lane: a DEPTH-stage delay line followed by the
// accumulate adder, which wraps with no saturation.
module psum_deskew_lane #(
  parameter int W     = 32,
  parameter int DEPTH = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] psum,
  input  logic [W-1:0] acc,
  output logic [W-1:0] aligned,
  output logic [W-1:0] sum
);
  if (DEPTH == 0) begin : g_thru
    logic unused_ok;
    assign unused_ok = &{1'b0, clk, rst_n};
    assign aligned   = psum;
  end else begin : g_dly
    logic [DEPTH-1:0][W-1:0] dly;
    // delay line that removes this column's skew
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        dly <= '0;
      end else begin
        dly[0] <= psum;
        for (int i = 1; i < DEPTH; i++) dly[i] <= dly[i-1];
      end
    end
    assign aligned = dly[DEPTH-1];
  end

  assign sum = aligned + acc;
endmodule

module psum_deskew_acc #(
  parameter int N_COLS     = 4,
  parameter int DATA_W_OUT = 32,
  parameter int ROWS_MAX   = 16,
  parameter int KT_W       = 8,
  parameter int FIFO_DEPTH = 8,
  localparam int RW        = $clog2(ROWS_MAX+1),
  localparam int VW        = N_COLS*DATA_W_OUT
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [RW-1:0] cfg_rows,
  input  logic [KT_W-1:0] cfg_ktiles,
  input  logic          in_valid,
  input  logic [VW-1:0] psum_in,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [VW-1:0] out_data,
  output logic          busy,
  output logic          done,
  output logic          almost_full,
  output logic          ovf_err
);
  localparam int STAGES = N_COLS-1;
  localparam int BW     = $clog2(ROWS_MAX);
  localparam int AW     = $clog2(FIFO_DEPTH);

  typedef enum logic {IDLE, RUN} state_t;
  state_t state, state_nxt;

  logic [STAGES:1]  vld_pipe;
  logic             aligned_valid, acc_en, start_acc, last_k;
  logic [VW-1:0]    vec, sum_vec, acc_rd;
  logic [RW-1:0]    m_lat, row_cnt;
  logic [KT_W-1:0]  k_lat, k_cnt;
  logic [VW-1:0]    acc_buf [ROWS_MAX];
  logic             res_vld, res_last;
  logic [VW-1:0]    res_data;
  logic [VW-1:0]    fifo_mem [FIFO_DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [AW:0]      cnt;
  logic             full, pop, push_ok;

  assign start_acc     = start && (state == IDLE);
  assign aligned_valid = vld_pipe[STAGES];
  assign acc_en        = aligned_valid && (state == RUN);
  assign last_k        = (k_cnt == k_lat - KT_W'(1));
  assign acc_rd        = acc_buf[row_cnt[BW-1:0]];

  // valid shift register that tracks column 0 to the aligned point
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe <= '0;
    end else begin
      vld_pipe[1] <= in_valid;
      for (int i = 2; i <= STAGES; i++) vld_pipe[i] <= vld_pipe[i-1];
    end
  end

  for (genvar j = 0; j < N_COLS; j++) begin : g_lane
    psum_deskew_lane #(.W(DATA_W_OUT), .DEPTH(N_COLS-1-j)) u_lane (
      .clk     (clk),
      .rst_n   (rst_n),
      .psum    (psum_in[j*DATA_W_OUT +: DATA_W_OUT]),
      .acc     (acc_rd[j*DATA_W_OUT +: DATA_W_OUT]),
      .aligned (vec[j*DATA_W_OUT +: DATA_W_OUT]),
      .sum     (sum_vec[j*DATA_W_OUT +: DATA_W_OUT])
    );
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // FSM next state: leave RUN right after the final row push
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start) state_nxt = RUN;
      RUN:  if (res_vld && res_last) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state == RUN);
  assign done = res_vld && res_last;

  // job config latch and row/K-tile counters; rows are clamped to the buffer depth
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_lat   <= '0;
      k_lat   <= '0;
      row_cnt <= '0;
      k_cnt   <= '0;
    end else if (start_acc) begin
      m_lat   <= (cfg_rows == '0) ? RW'(1) :
                 (cfg_rows > RW'(ROWS_MAX)) ? RW'(ROWS_MAX) : cfg_rows;
      k_lat   <= (cfg_ktiles == '0) ? KT_W'(1) : cfg_ktiles;
      row_cnt <= '0;
      k_cnt   <= '0;
    end else if (acc_en) begin
      if (row_cnt == m_lat - RW'(1)) begin
        row_cnt <= '0;
        k_cnt   <= k_cnt + KT_W'(1);
      end else begin
        row_cnt <= row_cnt + RW'(1);
      end
    end
  end

  // accumulation buffer: tile 0 overwrites, so no reset is needed
  always_ff @(posedge clk) begin
    if (acc_en && !last_k)
      acc_buf[row_cnt[BW-1:0]] <= (k_cnt == '0) ? vec : sum_vec;
  end

  // result register for the last K-tile, pushed to the FIFO next cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_vld  <= 1'b0;
      res_last <= 1'b0;
      res_data <= '0;
    end else begin
      res_vld  <= acc_en && last_k;
      res_last <= acc_en && last_k && (row_cnt == m_lat - RW'(1));
      if (acc_en && last_k)
        res_data <= (k_cnt == '0) ? vec : sum_vec;
    end
  end

  assign full        = (cnt == (AW+1)'(FIFO_DEPTH));
  assign out_valid   = (cnt != '0);
  assign pop         = out_valid && out_ready;
  assign push_ok     = res_vld && (!full || pop);
  assign almost_full = (cnt >= (AW+1)'(FIFO_DEPTH-2));
  assign out_data    = fifo_mem[rd_ptr];

  // output FIFO; a pop frees a slot for a same-cycle push when full
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) fifo_mem[i] <= '0;
    end else begin
      if (push_ok) begin
        fifo_mem[wr_ptr] <= res_data;
        wr_ptr           <= wr_ptr + AW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop})
        2'b10:   cnt <= cnt + (AW+1)'(1);
        2'b01:   cnt <= cnt - (AW+1)'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  // sticky overflow flag, cleared when a new job is accepted
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                       ovf_err <= 1'b0;
    else if (start_acc)               ovf_err <= 1'b0;
    else if (res_vld && full && !pop) ovf_err <= 1'b1;
  end
endmodule

// File: tb/tb_psum_deskew_acc.sv
// Scoreboard bench for psum_deskew_acc: the bench skews row vectors the
// way the array does, queues the expected finished rows and compares
// them as the FIFO is popped.
module tb_psum_deskew_acc;
  localparam int N  = 4;
  localparam int W  = 32;
  localparam int VW = N*W;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [4:0]    cfg_rows = '0;
  logic [7:0]    cfg_ktiles = '0;
  logic          in_valid = 1'b0;
  logic [VW-1:0] psum_in = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [VW-1:0] out_data;
  logic          busy, done, almost_full, ovf_err;

  int checks = 0;
  int errs = 0;
  int done_cnt = 0;
  logic [VW-1:0] exp_q [$];
  logic [VW-1:0] hist [N];

  psum_deskew_acc dut (
    .clk(clk), .rst_n(rst_n), .start(start), .cfg_rows(cfg_rows),
    .cfg_ktiles(cfg_ktiles), .in_valid(in_valid), .psum_in(psum_in),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .busy(busy), .done(done), .almost_full(almost_full), .ovf_err(ovf_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [VW-1:0] obs, input logic [VW-1:0] exp);
    checks++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [VW-1:0] mk(input int a, input int b, input int c, input int d);
    return {d[W-1:0], c[W-1:0], b[W-1:0], a[W-1:0]};
  endfunction

  function automatic logic [VW-1:0] fill(input logic [W-1:0] x);
    return {N{x}};
  endfunction

  // one clock: column j carries the vector issued j cycles earlier
  task automatic drive(input logic v, input logic [VW-1:0] vec);
    for (int j = N-1; j > 0; j--) hist[j] = hist[j-1];
    hist[0]  = vec;
    in_valid = v;
    for (int j = 0; j < N; j++) psum_in[j*W +: W] = hist[j][j*W +: W];
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input int rows, input int kt);
    cfg_rows   = rows[4:0];
    cfg_ktiles = kt[7:0];
    start      = 1'b1;
    drive(1'b0, '0);
    start      = 1'b0;
  endtask

  task automatic wait_drain(input int max_cyc);
    int n = 0;
    while (exp_q.size() != 0 && n < max_cyc) begin
      drive(1'b0, '0);
      n++;
    end
    chk("drain_timeout", exp_q.size(), 0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, '0);
  endtask

  // output monitor: pops the scoreboard on each FIFO handshake
  always @(negedge clk) begin
    if (rst_n) begin
      if (done) done_cnt++;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) chk("extra_out", out_valid & out_ready, 0);
        else chk("out_data", out_data, exp_q.pop_front());
      end
    end
  end

  initial begin
    int dc;
    for (int j = 0; j < N; j++) hist[j] = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_almost_full", almost_full, 0);
    chk("rst_ovf_err", ovf_err, 0);
    rst_n = 1'b1;
    idle(2);

    // basic M=2 K=1 with latency and done/busy timing
    out_ready = 1'b1;
    do_start(2, 1);
    chk("t1_busy", busy, 1);
    exp_q.push_back(mk(1, 2, 3, 4));
    drive(1'b1, mk(1, 2, 3, 4));
    exp_q.push_back(mk(5, 6, 7, 8));
    drive(1'b1, mk(5, 6, 7, 8));
    idle(2);
    chk("t1_lat_early", out_valid, 0);
    idle(1);
    chk("t1_lat_valid", out_valid, 1);
    chk("t1_done", done, 1);
    chk("t1_busy_at_done", busy, 1);
    idle(1);
    chk("t1_done_pulse", done, 0);
    chk("t1_busy_fall", busy, 0);
    wait_drain(20);
    chk("t1_done_cnt", done_cnt, 1);

    // M=1 K=3 accumulation
    do_start(1, 3);
    drive(1'b1, fill(1));
    drive(1'b1, fill(2));
    exp_q.push_back(fill(6));
    drive(1'b1, fill(3));
    wait_drain(20);
    idle(3);
    chk("t2_done_cnt", done_cnt, 2);

    // M=1 K=2 modulo wrap
    do_start(1, 2);
    drive(1'b1, fill(32'hFFFF_FFFF));
    exp_q.push_back(fill(1));
    drive(1'b1, fill(2));
    wait_drain(20);
    idle(3);

    // backpressure: M=10 K=1, FIFO fills, last two rows dropped
    out_ready = 1'b0;
    do_start(10, 1);
    for (int i = 0; i < 10; i++) begin
      if (i < 8) exp_q.push_back(fill(32'h100 + i));
      drive(1'b1, fill(32'h100 + i));
      if (i == 8) chk("t4_af_at5", almost_full, 0);
      if (i == 9) chk("t4_af_at6", almost_full, 1);
    end
    idle(6);
    chk("t4_ovf", ovf_err, 1);
    chk("t4_busy_done", busy, 0);
    chk("t4_done_cnt", done_cnt, 4);
    out_ready = 1'b1;
    wait_drain(30);
    chk("t4_drained", out_valid, 0);

    // start during RUN is ignored; new start clears ovf_err
    do_start(2, 1);
    chk("t5_ovf_clr", ovf_err, 0);
    exp_q.push_back(mk(9, 8, 7, 6));
    drive(1'b1, mk(9, 8, 7, 6));
    cfg_rows = 5'd3; cfg_ktiles = 8'd2; start = 1'b1;
    exp_q.push_back(mk(4, 3, 2, 1));
    drive(1'b1, mk(4, 3, 2, 1));
    start = 1'b0;
    wait_drain(20);
    idle(3);
    chk("t5_busy", busy, 0);
    chk("t5_done_cnt", done_cnt, 5);
    // in_valid while IDLE: nothing counted or pushed
    dc = done_cnt;
    drive(1'b1, fill(7));
    drive(1'b1, fill(8));
    drive(1'b1, fill(9));
    idle(8);
    chk("t5_idle_out", out_valid, 0);
    chk("t5_idle_done", done_cnt, dc);

    // reset mid-job with 3 vectors in the FIFO
    out_ready = 1'b0;
    do_start(4, 1);
    for (int i = 0; i < 4; i++) drive(1'b1, fill(32'hA0 + i));
    idle(3);
    chk("t6_pre_rst_valid", out_valid, 1);
    rst_n = 1'b0;
    exp_q.delete();
    drive(1'b0, '0);
    chk("t6_rst_valid", out_valid, 0);
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_ovf", ovf_err, 0);
    rst_n = 1'b1;
    out_ready = 1'b1;
    idle(2);
    do_start(2, 2);
    drive(1'b1, mk(10, 20, 30, 40));
    drive(1'b1, fill(1));
    exp_q.push_back(mk(11, 22, 33, 44));
    drive(1'b1, mk(1, 2, 3, 4));
    exp_q.push_back(fill(6));
    drive(1'b1, fill(5));
    wait_drain(20);
    idle(3);
    chk("t6_busy_end", busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errs);
    $finish;
  end
endmodule
